// File: rtl/vec_int_ctrl_if.sv
// Bus bundle between the vectored interrupt controller and its surroundings:
// interrupt sources, the CSR file, the EX stage and the pipeline hold logic.
// The controller connects through the slave modport; the core/environment
// side connects through the master modport.
interface vec_int_ctrl_if #(
  parameter int N_INT  = 8,
  parameter int DATA_W = 16
);
  logic [N_INT-1:0]         int_req;
  logic [N_INT-1:0]         int_mask;
  logic                     global_int_en;
  logic [DATA_W-1:0]        inst_addr;
  logic                     jump_flag;
  logic [DATA_W-1:0]        jump_addr;
  logic                     mret;
  logic [DATA_W-1:0]        csr_mtvec;
  logic [DATA_W-1:0]        csr_mepc;
  logic [DATA_W-1:0]        csr_mstatus;
  logic                     hold_flag_int;
  logic                     csr_we;
  logic [11:0]              csr_waddr;
  logic [DATA_W-1:0]        csr_wdata;
  logic                     int_assert;
  logic [DATA_W-1:0]        int_addr;
  logic [$clog2(N_INT)-1:0] int_id;

  modport master (
    output int_req, int_mask, global_int_en, inst_addr, jump_flag, jump_addr,
           mret, csr_mtvec, csr_mepc, csr_mstatus,
    input  hold_flag_int, csr_we, csr_waddr, csr_wdata, int_assert, int_addr,
           int_id
  );

  modport slave (
    input  int_req, int_mask, global_int_en, inst_addr, jump_flag, jump_addr,
           mret, csr_mtvec, csr_mepc, csr_mstatus,
    output hold_flag_int, csr_we, csr_waddr, csr_wdata, int_assert, int_addr,
           int_id
  );
endinterface

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: latches level/edge requests, arbitrates
// (fixed or round-robin), holds the pipeline while it saves mepc, mcause and
// mstatus, then redirects fetch to the trap vector. Also sequences mret.
module vec_int_ctrl #(
  parameter int               N_INT     = 8,
  parameter int               DATA_W    = 16,
  parameter logic [N_INT-1:0] EDGE_MASK = '0,
  parameter bit               RR_MODE   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  vec_int_ctrl_if.slave bus
);

  localparam int          ID_W         = $clog2(N_INT);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, ASSERT, MRET_STATUS, MRET_JUMP
  } state_t;

  state_t            state;
  logic [N_INT-1:0]  pend, req_q, elig, rise, clr, pend_nxt;
  logic [ID_W-1:0]   id, last_id, win_id;
  logic              win_vld, take_idle, mret_idle;
  logic [DATA_W-1:0] epc_sel;
  int                search_base, srch;

  logic              csr_we_r;
  logic [11:0]       csr_waddr_r;
  logic [DATA_W-1:0] csr_wdata_r;
  logic              int_assert_r;
  logic [DATA_W-1:0] int_addr_r;

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [DATA_W-1:0] trap_status(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r    = s;
    r[7] = s[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE restored from MPIE, MPIE set.
  function automatic logic [DATA_W-1:0] mret_status(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r    = s;
    r[3] = s[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Interrupt cause: MSB flags an interrupt, code 11 + channel.
  function automatic logic [DATA_W-1:0] cause_val(input logic [ID_W-1:0] ch);
    logic [DATA_W-1:0] r;
    r            = DATA_W'(11) + DATA_W'(ch);
    r[DATA_W-1]  = 1'b1;
    return r;
  endfunction

  // Trap target: mtvec mode 01 vectors by 4*channel, anything else is direct.
  function automatic logic [DATA_W-1:0] trap_target(input logic [DATA_W-1:0] tvec,
                                                    input logic [ID_W-1:0]   ch);
    logic [DATA_W-1:0] base;
    base = {tvec[DATA_W-1:2], 2'b00};
    if (tvec[1:0] == 2'b01) return base + (DATA_W'(ch) << 2);
    return base;
  endfunction

  assign elig        = pend & bus.int_mask;
  assign search_base = (!RR_MODE || int'(last_id) == N_INT - 1) ? 0 : int'(last_id) + 1;

  // Arbiter: first eligible channel scanning upward from the search base, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    srch    = 0;
    for (int k = 0; k < N_INT; k++) begin
      srch = search_base + k;
      if (srch >= N_INT) srch = srch - N_INT;
      if (!win_vld && elig[ID_W'(srch)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(srch);
      end
    end
  end

  // MRET outranks a take; both are only honoured while IDLE.
  assign mret_idle = (state == IDLE) && bus.mret;
  assign take_idle = (state == IDLE) && bus.global_int_en && win_vld && !bus.mret;
  assign epc_sel   = bus.jump_flag ? bus.jump_addr : bus.inst_addr;

  // Edge channels latch a rising edge until taken (a new edge beats the clear);
  // level channels simply follow the request one cycle late.
  assign rise     = bus.int_req & ~req_q;
  assign clr      = take_idle ? (N_INT'(1) << win_id) : '0;
  assign pend_nxt = (EDGE_MASK & (rise | (pend & ~clr))) | (~EDGE_MASK & bus.int_req);

  // Pending and edge-detect registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend  <= '0;
      req_q <= '0;
    end else begin
      pend  <= pend_nxt;
      req_q <= bus.int_req;
    end
  end

  // Save/return sequencer; outputs are registered alongside the next state,
  // so the mepc value captured on take lives in the write-data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      id           <= '0;
      last_id      <= ID_W'(N_INT - 1);
      csr_we_r     <= 1'b0;
      csr_waddr_r  <= '0;
      csr_wdata_r  <= '0;
      int_assert_r <= 1'b0;
      int_addr_r   <= '0;
    end else begin
      csr_we_r     <= 1'b0;
      csr_waddr_r  <= '0;
      csr_wdata_r  <= '0;
      int_assert_r <= 1'b0;
      int_addr_r   <= '0;
      unique case (state)
        IDLE: begin
          if (mret_idle) begin
            state       <= MRET_STATUS;
            csr_we_r    <= 1'b1;
            csr_waddr_r <= ADDR_MSTATUS;
            csr_wdata_r <= mret_status(bus.csr_mstatus);
          end else if (take_idle) begin
            state       <= SAVE_EPC;
            id          <= win_id;
            last_id     <= win_id;
            csr_we_r    <= 1'b1;
            csr_waddr_r <= ADDR_MEPC;
            csr_wdata_r <= epc_sel;
          end
        end
        SAVE_EPC: begin
          state       <= SAVE_CAUSE;
          csr_we_r    <= 1'b1;
          csr_waddr_r <= ADDR_MCAUSE;
          csr_wdata_r <= cause_val(id);
        end
        SAVE_CAUSE: begin
          state       <= SAVE_STATUS;
          csr_we_r    <= 1'b1;
          csr_waddr_r <= ADDR_MSTATUS;
          csr_wdata_r <= trap_status(bus.csr_mstatus);
        end
        SAVE_STATUS: begin
          state        <= ASSERT;
          int_assert_r <= 1'b1;
          int_addr_r   <= trap_target(bus.csr_mtvec, id);
        end
        MRET_STATUS: begin
          state        <= MRET_JUMP;
          int_assert_r <= 1'b1;
          int_addr_r   <= bus.csr_mepc;
        end
        ASSERT, MRET_JUMP: state <= IDLE;
        default:           state <= IDLE;
      endcase
    end
  end

  assign bus.hold_flag_int = (state != IDLE) || take_idle || mret_idle;
  assign bus.csr_we        = csr_we_r;
  assign bus.csr_waddr     = csr_waddr_r;
  assign bus.csr_wdata     = csr_wdata_r;
  assign bus.int_assert    = int_assert_r;
  assign bus.int_addr      = int_addr_r;
  assign bus.int_id        = id;

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Bench for vec_int_ctrl: a fixed-priority and a round-robin instance share
// one stimulus stream; a transaction-level model predicts every output cycle.
module tb_vec_int_ctrl;

  localparam int         NI    = 8;
  localparam int         DW    = 16;
  localparam logic [7:0] EMASK = 8'h20;

  typedef struct packed {
    logic        we;
    logic [11:0] waddr;
    logic [15:0] wdata;
    logic        asrt;
    logic [15:0] iaddr;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0]  req, mask;
  logic        gie, jf, mret;
  logic [15:0] iaddr, ja, mtvec, mepc, mst;

  always #5 clk = ~clk;

  vec_int_ctrl_if #(.N_INT(NI), .DATA_W(DW)) if0 ();
  vec_int_ctrl_if #(.N_INT(NI), .DATA_W(DW)) if1 ();

  assign if0.int_req = req;   assign if1.int_req = req;
  assign if0.int_mask = mask; assign if1.int_mask = mask;
  assign if0.global_int_en = gie; assign if1.global_int_en = gie;
  assign if0.inst_addr = iaddr;   assign if1.inst_addr = iaddr;
  assign if0.jump_flag = jf;      assign if1.jump_flag = jf;
  assign if0.jump_addr = ja;      assign if1.jump_addr = ja;
  assign if0.mret = mret;         assign if1.mret = mret;
  assign if0.csr_mtvec = mtvec;   assign if1.csr_mtvec = mtvec;
  assign if0.csr_mepc = mepc;     assign if1.csr_mepc = mepc;
  assign if0.csr_mstatus = mst;   assign if1.csr_mstatus = mst;

  vec_int_ctrl #(.N_INT(NI), .DATA_W(DW), .EDGE_MASK(EMASK), .RR_MODE(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  vec_int_ctrl #(.N_INT(NI), .DATA_W(DW), .EDGE_MASK(EMASK), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int hold_cnt = 0;

  // Reference model state, index 0 = fixed priority, 1 = round-robin.
  rec_t       seq [2][4];
  int         nseq [2];
  int         pos [2];
  logic [7:0] m_pend [2];
  logic [7:0] m_reqq [2];
  int         m_id [2];
  int         m_last [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic rec_t mkrec(input logic we, input logic [11:0] a, input logic [15:0] d,
                                 input logic asrt, input logic [15:0] ia);
    rec_t r;
    r.we = we; r.waddr = a; r.wdata = d; r.asrt = asrt; r.iaddr = ia;
    return r;
  endfunction

  // Winner: lowest index, or for round-robin the eligible channel closest
  // after the last one granted (circular distance).
  function automatic int pick(input int k, input logic [7:0] elig);
    int best, bestd, d;
    best = -1; bestd = NI;
    for (int i = 0; i < NI; i++) begin
      if (elig[i]) begin
        d = (k == 0) ? i : (i - m_last[k] - 1 + 2 * NI) % NI;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  function automatic bit model_idle(input int k);
    return pos[k] >= nseq[k];
  endfunction

  task automatic model_update();
    logic [7:0]  elig, rise;
    logic [15:0] epc, stat, tgt;
    int          w;
    bit          tk;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        nseq[k] = 0; pos[k] = 0; m_pend[k] = '0; m_reqq[k] = '0;
        m_id[k] = 0; m_last[k] = NI - 1;
      end else begin
        tk = 1'b0; w = 0;
        elig = m_pend[k] & mask;
        if (!model_idle(k)) pos[k]++;
        else if (mret) begin
          stat = (mst & 16'hFF77) | (mst[7] ? 16'h0008 : 16'h0000) | 16'h0080;
          seq[k][0] = mkrec(1'b1, 12'h300, stat, 1'b0, 16'h0);
          seq[k][1] = mkrec(1'b0, 12'h000, 16'h0, 1'b1, mepc);
          nseq[k] = 2; pos[k] = 0;
        end else if (gie && elig != 0) begin
          w = pick(k, elig); tk = 1'b1;
          epc  = jf ? ja : iaddr;
          stat = (mst & 16'hFF77) | (mst[3] ? 16'h0080 : 16'h0000);
          tgt  = (mtvec & 16'hFFFC) + ((mtvec & 16'h3) == 16'h1 ? 16'(4 * w) : 16'h0);
          seq[k][0] = mkrec(1'b1, 12'h341, epc, 1'b0, 16'h0);
          seq[k][1] = mkrec(1'b1, 12'h342, 16'(32768 + 11 + w), 1'b0, 16'h0);
          seq[k][2] = mkrec(1'b1, 12'h300, stat, 1'b0, 16'h0);
          seq[k][3] = mkrec(1'b0, 12'h000, 16'h0, 1'b1, tgt);
          nseq[k] = 4; pos[k] = 0; m_id[k] = w; m_last[k] = w;
        end
        rise = req & ~m_reqq[k];
        for (int i = 0; i < NI; i++) begin
          if (EMASK[i]) m_pend[k][i] = rise[i] | (m_pend[k][i] & !(tk && w == i));
          else          m_pend[k][i] = req[i];
        end
        m_reqq[k] = req;
      end
    end
  endtask

  task automatic check_outputs();
    rec_t        e;
    logic        a_we, a_as, a_hold, e_hold;
    logic [11:0] a_wa;
    logic [15:0] a_wd, a_ia;
    logic [2:0]  a_id;
    if (if0.hold_flag_int === 1'b1) hold_cnt++;
    if (!chk_en) return;
    for (int k = 0; k < 2; k++) begin
      e = model_idle(k) ? '0 : seq[k][pos[k]];
      e_hold = !model_idle(k) || mret || (gie && (m_pend[k] & mask) != 0);
      if (k == 0) begin
        a_we = if0.csr_we; a_wa = if0.csr_waddr; a_wd = if0.csr_wdata;
        a_as = if0.int_assert; a_ia = if0.int_addr; a_id = if0.int_id; a_hold = if0.hold_flag_int;
      end else begin
        a_we = if1.csr_we; a_wa = if1.csr_waddr; a_wd = if1.csr_wdata;
        a_as = if1.int_assert; a_ia = if1.int_addr; a_id = if1.int_id; a_hold = if1.hold_flag_int;
      end
      chk($sformatf("u%0d csr_we", k),     32'(a_we),   32'(e.we));
      chk($sformatf("u%0d csr_waddr", k),  32'(a_wa),   32'(e.waddr));
      chk($sformatf("u%0d csr_wdata", k),  32'(a_wd),   32'(e.wdata));
      chk($sformatf("u%0d int_assert", k), 32'(a_as),   32'(e.asrt));
      chk($sformatf("u%0d int_addr", k),   32'(a_ia),   32'(e.iaddr));
      chk($sformatf("u%0d int_id", k),     32'(a_id),   32'(m_id[k]));
      chk($sformatf("u%0d hold", k),       32'(a_hold), 32'(e_hold));
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  logic [31:0] r0, r1, r2;

  initial begin
    rst_n = 1'b0; req = '0; mask = 8'hFF; gie = 1'b0; jf = 1'b0; mret = 1'b0;
    iaddr = 16'h1234; ja = 16'h0; mtvec = 16'h0100; mepc = 16'h0; mst = 16'h0008;
    step();
    chk_en = 1'b1;
    step();
    chk("reset int_id", 32'(if0.int_id), 32'h0);
    chk("reset csr_we", 32'(if1.csr_we), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // Fixed priority, direct mode: level channels 2 and 5, one trap.
    hold_cnt = 0;
    req = 8'b0010_0100; gie = 1'b1;
    step(); step();
    gie = 1'b0;
    cyc(6);
    chk("trap hold cycles", 32'(hold_cnt), 32'd5);
    req = '0;
    cyc(2);

    // Vectored mode, edge channel 5 pulse; then a new edge in the clear cycle.
    mtvec = 16'h0201; gie = 1'b1;
    req = 8'h20; step(); req = '0;
    cyc(8);
    gie = 1'b0; req = 8'h20; step();
    req = '0; step();
    gie = 1'b1; req = 8'h20; step();
    req = '0; gie = 1'b0;
    cyc(6);
    gie = 1'b1; cyc(8);
    gie = 1'b0; cyc(2);

    // Jump in flight during the take cycle.
    mtvec = 16'h0100;
    req = 8'h08; gie = 1'b1; step();
    jf = 1'b1; ja = 16'h0ABC; step();
    jf = 1'b0; gie = 1'b0; req = '0;
    cyc(6);

    // Round-robin between channels 1 and 3, MIE re-enabled between traps.
    req = 8'h0A; step();
    for (int r = 0; r < 4; r++) begin
      gie = 1'b1; step();
      chk($sformatf("rr grant %0d", r), 32'(if1.int_id), (r % 2 == 0) ? 32'd1 : 32'd3);
      chk($sformatf("fixed grant %0d", r), 32'(if0.int_id), 32'd1);
      gie = 1'b0; cyc(5);
    end
    req = '0; cyc(3);

    // MRET with a pending interrupt that must wait for IDLE.
    mst = 16'h0080; mepc = 16'h0042;
    req = 8'h01; gie = 1'b1; step();
    mret = 1'b1; step();
    mret = 1'b0; cyc(10);
    gie = 1'b0; req = '0; cyc(6);

    // Reset during SAVE_CAUSE, level request persists afterwards.
    mst = 16'h0008; mtvec = 16'h0100;
    req = 8'h04; gie = 1'b1; step(); step(); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; cyc(10);
    gie = 1'b0; req = '0; cyc(6);

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      req   = r0[7:0] & r0[15:8];
      mask  = ($urandom_range(0, 3) == 0) ? r0[23:16] : 8'hFF;
      gie   = ($urandom_range(0, 3) != 0);
      mret  = ($urandom_range(0, 15) == 0);
      jf    = r0[24];
      ja    = r1[15:0];
      iaddr = r1[31:16];
      if (model_idle(0) && model_idle(1) && $urandom_range(0, 7) == 0) begin
        mtvec = r2[15:0];
        if (r2[31]) mtvec[1:0] = 2'b01;
        mst  = r2[31:16];
        mepc = r1[15:0] ^ r2[15:0];
      end
      step();
    end
    rst_n = 1'b1; req = '0; gie = 1'b0; mret = 1'b0;
    cyc(6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vec_int_ctrl.md
# vec_int_ctrl

Parametrised vectored interrupt controller for the pipelined core, sitting between external interrupt sources, the CSR file and the pipeline `ctrl` hold logic. It latches N interrupt requests (per-channel level or edge), selects one by fixed or round-robin priority, freezes the pipeline and runs a multi-cycle CSR save sequence (mepc, mcause, mstatus). It then redirects fetch to a direct or vectored trap address. It also sequences `mret` returns.

## Interface
Parameters:
- `N_INT`, 8: number of interrupt channels (2..16).
- `DATA_W`, 16: CSR/PC data width (≥ 8).
- `EDGE_MASK`, {N_INT{1'b0}}: bit i = 1 → channel i rising-edge triggered, else level.
- `RR_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `int_req` in N_INT: raw interrupt requests, already synchronous to `clk`.
- `int_mask` in N_INT: per-channel enable (mie).
- `global_int_en` in 1: mstatus.MIE from CSR.
- `inst_addr` in DATA_W: PC to resume at if no jump is in flight.
- `jump_flag` in 1, `jump_addr` in DATA_W: EX-stage redirect.
- `mret` in 1: decoded MRET in EX.
- `csr_mtvec`, `csr_mepc`, `csr_mstatus` in DATA_W: current CSR values.
- `hold_flag_int` out 1: pipeline hold request to `ctrl`.
- `csr_we` out 1, `csr_waddr` out 12, `csr_wdata` out DATA_W: CSR write port.
- `int_assert` out 1: one-cycle fetch redirect strobe.
- `int_addr` out DATA_W: redirect target, valid with `int_assert`.
- `int_id` out $clog2(N_INT): channel being serviced.

## Operation
- Pending: level channel i: `pend[i] = int_req[i]`, registered each cycle. Edge channel i: set on `int_req[i]` & ~`req_q[i]`, cleared on take of channel i. Set wins over clear in the same cycle.
- Take condition in IDLE: `global_int_en & |(pend & int_mask) & ~mret`. The winner comes from the arbiter. In round-robin mode the search starts at `last_id+1` and wraps mod N_INT. `last_id` resets to N_INT-1.
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, ASSERT, MRET_STATUS, MRET_JUMP.
- IDLE → SAVE_EPC on take. This latches `id`, `epc = jump_flag ? jump_addr : inst_addr` and `last_id = id`. MRET has priority over take: IDLE → MRET_STATUS.
- SAVE_EPC: `csr_we`=1, addr 0x341, data `epc` → SAVE_CAUSE.
- SAVE_CAUSE: addr 0x342, data = MSB 1, low bits = `11 + id` zero-extended → SAVE_STATUS.
- SAVE_STATUS: addr 0x300, data = `csr_mstatus` with bit7 (MPIE) = bit3, bit3 (MIE) = 0 → ASSERT.
- ASSERT: `int_assert`=1. If `csr_mtvec[1:0]==2'b01`, `int_addr` = `{mtvec[DW-1:2],2'b00} + 4*id`; else `int_addr` = `{mtvec[DW-1:2],2'b00}`. Addition wraps mod 2^DATA_W. → IDLE.
- MRET_STATUS: addr 0x300, data = `csr_mstatus` with bit3 = bit7, bit7 = 1 → MRET_JUMP.
- MRET_JUMP: `int_assert`=1, `int_addr` = `csr_mepc` → IDLE.
- Once a sequence has started it always completes. Changes to `global_int_en`, `int_mask` or `int_req` mid-sequence do not abort it. `mret` and requests are ignored outside IDLE; edge pendings still latch.
- `csr_we`/`csr_waddr`/`csr_wdata`/`int_assert`/`int_addr` are decoded from state (Moore). They are 0 when not in an active state.

## Timing
- Reset (`rst_n`=0 at a clk edge): state IDLE, `pend`=0, `req_q`=0, `id`=0, `epc`=0, `last_id`=N_INT-1. All outputs 0 the following cycle. Reset mid-sequence abandons it and no further CSR writes occur.
- `hold_flag_int` is combinational. It is 1 in the IDLE cycle where take or `mret` is true, and in every non-IDLE state.
- Interrupt latency: request at `int_req` in cycle T → `pend` in T+1 → take in T+1 → SAVE_EPC T+2, SAVE_CAUSE T+3, SAVE_STATUS T+4, ASSERT T+5 → IDLE T+6. An edge on `int_req` is needed only for one cycle.
- MRET: `mret` in cycle M → MRET_STATUS M+1, MRET_JUMP M+2, IDLE M+3.
- Back-to-back: a new take is possible in the first IDLE cycle after ASSERT. Normally it is blocked because MIE was cleared.

## Test plan
- Fixed priority, N_INT=8, mtvec=0x0100 direct: level req 0b0010_0100 with mask 0xFF, MIE=1 → writes mepc=inst_addr, mcause=0x800D (DATA_W=16, id 2), mstatus MIE→0/MPIE→1, then `int_assert` with `int_addr`=0x0100, `int_id`=2, exactly 5 hold cycles.
- Vectored: mtvec=0x0201, edge channel 5 single-cycle pulse → `int_addr`=0x0214. `pend[5]` is cleared after take. A second pulse coinciding with the clear cycle keeps `pend[5]`=1.
- Jump in flight: `jump_flag`=1, `jump_addr`=0x0ABC in the take cycle → mepc written 0x0ABC.
- Round-robin: channels 1 and 3 held high, MIE re-enabled between traps → grants 1, 3, 1, 3.
- MRET: mstatus=0x0080, mepc=0x0042, `mret` pulse → mstatus written 0x0088, `int_assert` with 0x0042. A simultaneous pending interrupt is deferred until IDLE.
- Reset asserted during SAVE_CAUSE → no SAVE_STATUS write, outputs 0, `pend` cleared; interrupt re-taken after `rst_n` rises if the level request persists.
